// File: rtl/apb_node_pkg.sv
// Shared definitions for the registered APB 1-to-N node.
//  - node_state_e : FSM state encoding used by apb_node_reg
//  - default peripheral address map (UART .. DEBUG), inclusive start/end
//  - idx_width()  : width of a port index for a given port count
package apb_node_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR    = 3'd3,
        ST_RESP   = 3'd4
    } node_state_e;

    localparam int NB_DEFAULT_PORTS = 10;

    localparam logic [31:0] UART_START     = 32'h1A10_0000, UART_END     = 32'h1A10_0FFF;
    localparam logic [31:0] GPIO_START     = 32'h1A10_1000, GPIO_END     = 32'h1A10_1FFF;
    localparam logic [31:0] SPI_START      = 32'h1A10_2000, SPI_END      = 32'h1A10_2FFF;
    localparam logic [31:0] TIMER_START    = 32'h1A10_3000, TIMER_END    = 32'h1A10_3FFF;
    localparam logic [31:0] EVENT_START    = 32'h1A10_4000, EVENT_END    = 32'h1A10_4FFF;
    localparam logic [31:0] I2C_START      = 32'h1A10_5000, I2C_END      = 32'h1A10_5FFF;
    localparam logic [31:0] FLL_START      = 32'h1A10_6000, FLL_END      = 32'h1A10_6FFF;
    localparam logic [31:0] SOC_CTRL_START = 32'h1A10_7000, SOC_CTRL_END = 32'h1A10_7FFF;
    localparam logic [31:0] CIPHER_START   = 32'h1A10_8000, CIPHER_END   = 32'h1A10_8FFF;
    localparam logic [31:0] DEBUG_START    = 32'h1A11_0000, DEBUG_END    = 32'h1A11_7FFF;

    localparam logic [31:0] DEF_START_ADDR [NB_DEFAULT_PORTS] = '{
        UART_START, GPIO_START, SPI_START, TIMER_START, EVENT_START,
        I2C_START, FLL_START, SOC_CTRL_START, CIPHER_START, DEBUG_START};
    localparam logic [31:0] DEF_END_ADDR [NB_DEFAULT_PORTS] = '{
        UART_END, GPIO_END, SPI_END, TIMER_END, EVENT_END,
        I2C_END, FLL_END, SOC_CTRL_END, CIPHER_END, DEBUG_END};

    // A single-port node still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational priority address decoder.
//  i_addr       : address to decode
//  i_start_addr : packed inclusive region starts, port i at [i*AW +: AW]
//  i_end_addr   : packed inclusive region ends,   port i at [i*AW +: AW]
//  o_hit        : at least one region contains i_addr
//  o_idx        : lowest-index matching port (0 when no hit)
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = idx_width(NB_MASTER)
) (
    input  logic [APB_ADDR_WIDTH-1:0]           i_addr,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] i_start_addr,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] i_end_addr,
    output logic                                o_hit,
    output logic [IDX_W-1:0]                    o_idx
);

    logic [NB_MASTER-1:0] w_hit;

    // A region with start > end can never satisfy both bounds, so it is
    // naturally disabled without a separate check.
    generate
        for (genvar gi = 0; gi < NB_MASTER; gi++) begin : g_region
            logic [APB_ADDR_WIDTH-1:0] w_start;
            logic [APB_ADDR_WIDTH-1:0] w_end;
            assign w_start   = i_start_addr[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            assign w_end     = i_end_addr[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            assign w_hit[gi] = (i_addr >= w_start) && (i_addr <= w_end);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last written.
    always_comb begin
        o_hit = |w_hit;
        o_idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (w_hit[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/apb_node_reg.sv
// Registered APB 1-to-NB_MASTER node.
// One upstream APB slave port (s_*) is re-sequenced onto NB_MASTER downstream
// APB master ports (m_*) sharing address/data/write; the map comes from the
// runtime start_addr/end_addr inputs. Unmapped accesses end locally with
// PSLVERR. Optional ACCESS timeout is enabled by defining APB_NODE_TIMEOUT_EN.
//  clk, rst          : clock, asynchronous active-high reset
//  s_paddr..s_penable: upstream request;  s_prdata/s_pready/s_pslverr: response
//  m_paddr/m_pwdata/m_pwrite : shared downstream request fields
//  m_psel/m_penable  : per-port select/enable (select is one-hot or zero)
//  m_prdata/m_pready/m_pslverr : per-port downstream response, packed
//  start_addr/end_addr : per-port inclusive regions, packed
//  timeout           : one-cycle pulse when an ACCESS is forcibly ended
module apb_node_reg
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata,
    input  logic                                s_pwrite,
    input  logic                                s_psel,
    input  logic                                s_penable,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata,
    output logic                                s_pready,
    output logic                                s_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]           m_paddr,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata,
    output logic                                m_pwrite,
    output logic [NB_MASTER-1:0]                m_psel,
    output logic [NB_MASTER-1:0]                m_penable,
    input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] m_prdata,
    input  logic [NB_MASTER-1:0]                m_pready,
    input  logic [NB_MASTER-1:0]                m_pslverr,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr,
    output logic                                timeout
);

    localparam int IDX_W = idx_width(NB_MASTER);

    node_state_e               r_state;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic                      r_write;
    logic [IDX_W-1:0]          r_idx;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;

    logic                      w_dec_hit;
    logic [IDX_W-1:0]          w_dec_idx;
    logic                      w_active;
    logic [APB_DATA_WIDTH-1:0] w_prdata [NB_MASTER];

`ifdef APB_NODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
`endif

    apb_addr_decoder #(
        .NB_MASTER      (NB_MASTER),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_decoder (
        .i_addr       (s_paddr),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .o_hit        (w_dec_hit),
        .o_idx        (w_dec_idx)
    );

    // Selects come straight from the state register, so an asynchronous
    // reset drops them in the same instant.
    assign w_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

    generate
        for (genvar gi = 0; gi < NB_MASTER; gi++) begin : g_port
            assign w_prdata[gi]  = m_prdata[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            assign m_psel[gi]    = w_active && (r_idx == IDX_W'(gi));
            assign m_penable[gi] = (r_state == ST_ACCESS) && (r_idx == IDX_W'(gi));
        end
    endgenerate

    assign m_paddr   = r_addr;
    assign m_pwdata  = r_wdata;
    assign m_pwrite  = r_write;
    assign s_prdata  = r_rdata;
    assign s_pready  = (r_state == ST_RESP) && s_psel && s_penable;
    assign s_pslverr = s_pready && r_err;

`ifdef APB_NODE_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    // Feature compiled out: constant 0; the parameter is still referenced so
    // the interface is identical across builds.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef APB_NODE_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // psel with penable already high is a protocol
                    // violation and is deliberately not accepted.
                    if (s_psel && !s_penable) begin
                        r_addr  <= s_paddr;
                        r_wdata <= s_pwdata;
                        r_write <= s_pwrite;
                        r_idx   <= w_dec_idx;
                        r_state <= w_dec_hit ? ST_SETUP : ST_ERR;
                    end
                end
                ST_SETUP: begin
`ifdef APB_NODE_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_pready[r_idx]) begin
                        r_rdata <= w_prdata[r_idx];
                        r_err   <= m_pslverr[r_idx];
                        r_state <= ST_RESP;
                    end
`ifdef APB_NODE_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_ERR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // Leave on the completing access phase, or silently if
                    // the upstream abandoned the transfer.
                    if (!s_psel || s_penable) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_node_reg.sv
module tb_apb_node_reg;
    import apb_node_pkg::*;

    localparam int NB = 10;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB_NODE_TIMEOUT_EN
    localparam int TO = 8;
    localparam int EXP_TO_PULSES = 1;
`else
    localparam int TO = 256;
    localparam int EXP_TO_PULSES = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]    s_paddr = '0;
    logic [DW-1:0]    s_pwdata = '0;
    logic             s_pwrite = 1'b0;
    logic             s_psel = 1'b0;
    logic             s_penable = 1'b0;
    logic [DW-1:0]    s_prdata;
    logic             s_pready;
    logic             s_pslverr;
    logic [AW-1:0]    m_paddr;
    logic [DW-1:0]    m_pwdata;
    logic             m_pwrite;
    logic [NB-1:0]    m_psel;
    logic [NB-1:0]    m_penable;
    logic [NB*DW-1:0] m_prdata;
    logic [NB-1:0]    m_pready;
    logic [NB-1:0]    m_pslverr;
    logic [NB*AW-1:0] start_addr;
    logic [NB*AW-1:0] end_addr;
    logic             timeout;

    apb_node_reg #(
        .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_psel(s_psel), .s_penable(s_penable),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .start_addr(start_addr), .end_addr(end_addr), .timeout(timeout)
    );

    // Downstream slave models: per-port map, wait states, read data, error.
    logic [31:0] st [NB];
    logic [31:0] en [NB];
    int          wait_cfg [NB];
    logic [31:0] rdata_cfg [NB];
    logic        err_cfg [NB];
    int          acc_cnt [NB];
    bit [NB-1:0] noise = '0;
    int          to_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always_comb begin
        start_addr = '0;
        end_addr   = '0;
        m_prdata   = '0;
        m_pslverr  = '0;
        m_pready   = '0;
        for (int i = 0; i < NB; i++) begin
            start_addr[i*AW +: AW] = st[i];
            end_addr[i*AW +: AW]   = en[i];
            m_prdata[i*DW +: DW]   = rdata_cfg[i];
            m_pslverr[i]           = err_cfg[i];
            // Unselected ports may raise ready spuriously; the node must ignore them.
            m_pready[i] = (m_psel[i] && m_penable[i] && (acc_cnt[i] >= wait_cfg[i]))
                        || (noise[i] && !m_psel[i]);
        end
    end

    always @(posedge clk) begin
        noise <= NB'($urandom);
        for (int i = 0; i < NB; i++)
            acc_cnt[i] <= (m_psel[i] && m_penable[i] && !m_pready[i]) ? acc_cnt[i] + 1 : 0;
    end

    always @(negedge clk) if (timeout === 1'b1) to_cnt <= to_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural map: first region (lowest index) containing the address.
    function automatic int ref_port(input logic [31:0] a);
        for (int i = 0; i < NB; i++)
            if (st[i] <= a && a <= en[i]) return i;
        return -1;
    endfunction

    // One upstream transfer; setup is cycle 0, returns cycle of s_pready.
    task automatic run_xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                            input logic wr, input int exp_lat, input logic [31:0] exp_rd,
                            input logic exp_er, input logic [NB-1:0] exp_mask);
        int            lat = -1;
        logic [31:0]   rd = '0;
        logic          er = 1'b0;
        logic [NB-1:0] mask = '0;
        logic          onehot_ok = 1'b1;
        logic          stable_ok = 1'b1;
        logic          clear_ok = 1'b0;
        @(posedge clk); #1;
        s_paddr = a; s_pwdata = wd; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
        @(negedge clk);
        mask |= m_psel;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            s_penable = 1'b1;
            @(negedge clk);
            mask |= m_psel;
            if ($countones(m_psel) > 1 || (m_penable & ~m_psel) != '0) onehot_ok = 1'b0;
            if (m_psel != '0 && (m_paddr !== a || m_pwdata !== wd || m_pwrite !== wr))
                stable_ok = 1'b0;
            if (s_pready === 1'b1) begin
                lat = c; rd = s_prdata; er = s_pslverr;
                clear_ok = (m_psel == '0) && (m_penable == '0);
                break;
            end
        end
        @(posedge clk); #1;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        @(negedge clk);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prdata"}, 64'(rd), 64'(exp_rd));
        chk({tag, "_pslverr"}, 64'(er), 64'(exp_er));
        chk({tag, "_psel_seen"}, 64'(mask), 64'(exp_mask));
        chk({tag, "_onehot"}, 64'(onehot_ok), 64'd1);
        chk({tag, "_bus_stable"}, 64'(stable_ok), 64'd1);
        chk({tag, "_sel_cleared"}, 64'(clear_ok), 64'd1);
        chk({tag, "_prdata_hold"}, 64'(s_prdata), 64'(exp_rd));
        chk({tag, "_idle_pready"}, 64'(s_pready), 64'd0);
        $display("xfer %s addr=%h wr=%0b wdata=%h lat=%0d prdata=%h pslverr=%0b psel=%h",
                 tag, a, wr, wd, lat, rd, er, mask);
    endtask

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          wr;
        int            lat;
        logic [31:0]   rd;
        logic          er;
        logic [NB-1:0] mask;
    } vec_t;

    vec_t vecs [10];

    initial begin
        for (int i = 0; i < NB; i++) begin
            st[i] = DEF_START_ADDR[i];
            en[i] = DEF_END_ADDR[i];
            wait_cfg[i] = 0;
            rdata_cfg[i] = 32'hA5A5_0000 + 32'(i);
            err_cfg[i] = 1'b0;
            acc_cnt[i] = 0;
        end
        wait_cfg[3] = 4;     // TIMER
        err_cfg[8]  = 1'b1;  // CIPHER reports a slave error

        vecs[0] = '{32'h1A10_1004, 32'h0,          1'b0, 3, 32'hA5A5_0001, 1'b0, 10'h002};
        vecs[1] = '{32'h1A10_3008, 32'h1234_5678, 1'b1, 7, 32'hA5A5_0003, 1'b0, 10'h008};
        vecs[2] = '{32'h2000_0000, 32'h0,          1'b0, 2, 32'h0,          1'b1, 10'h000};
        vecs[3] = '{32'h1A10_0FFF, 32'h0,          1'b0, 3, 32'hA5A5_0000, 1'b0, 10'h001};
        vecs[4] = '{32'h1A10_1000, 32'hDEAD_BEEF, 1'b1, 3, 32'hA5A5_0001, 1'b0, 10'h002};
        vecs[5] = '{32'h1A11_7FFF, 32'h0,          1'b0, 3, 32'hA5A5_0009, 1'b0, 10'h200};
        vecs[6] = '{32'h1A11_8000, 32'h0,          1'b0, 2, 32'h0,          1'b1, 10'h000};
        vecs[7] = '{32'h1A10_8010, 32'h0,          1'b0, 3, 32'hA5A5_0008, 1'b1, 10'h100};
        vecs[8] = '{32'hFFFF_FFFF, 32'h0,          1'b0, 2, 32'h0,          1'b1, 10'h000};
        vecs[9] = '{32'h1A10_7ABC, 32'h0BAD_F00D, 1'b1, 3, 32'hA5A5_0007, 1'b0, 10'h080};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_prdata", 64'(s_prdata), 64'd0);
        chk("rst_s_pready", 64'(s_pready), 64'd0);
        chk("rst_s_pslverr", 64'(s_pslverr), 64'd0);
        chk("rst_m_paddr", 64'(m_paddr), 64'd0);
        chk("rst_m_pwdata", 64'(m_pwdata), 64'd0);
        chk("rst_m_pwrite", 64'(m_pwrite), 64'd0);
        chk("rst_m_psel", 64'(m_psel), 64'd0);
        chk("rst_m_penable", 64'(m_penable), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed vector table
        for (int v = 0; v < 10; v++)
            run_xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wdata, vecs[v].wr,
                     vecs[v].lat, vecs[v].rd, vecs[v].er, vecs[v].mask);

        // Overlapping regions: port 3 moved over GPIO, lowest index wins
        st[3] = 32'h1A10_1000; en[3] = 32'h1A10_1FFF;
        run_xfer("overlap", 32'h1A10_1800, 32'h0, 1'b0, 3, 32'hA5A5_0001, 1'b0, 10'h002);
        st[3] = TIMER_START; en[3] = TIMER_END;

        // Inverted region never hits
        st[1] = 32'h1A10_1FFF; en[1] = 32'h1A10_1000;
        run_xfer("inverted", 32'h1A10_1800, 32'h0, 1'b0, 2, 32'h0, 1'b1, 10'h000);
        st[1] = GPIO_START; en[1] = GPIO_END;

        // psel+penable together in IDLE is ignored
        @(posedge clk); #1;
        s_paddr = 32'h1A10_1004; s_psel = 1'b1; s_penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("violation_psel", 64'(m_psel), 64'd0);
            chk("violation_pready", 64'(s_pready), 64'd0);
            @(posedge clk); #1;
        end
        s_psel = 1'b0; s_penable = 1'b0;
        run_xfer("after_violation", 32'h1A10_1004, 32'h0, 1'b0, 3, 32'hA5A5_0001, 1'b0, 10'h002);

        // Upstream drops psel while the node sits in RESP
        @(posedge clk); #1;
        s_paddr = 32'h2000_0000; s_psel = 1'b1; s_penable = 1'b0;
        @(posedge clk); #1; s_penable = 1'b1;
        @(posedge clk); #1; s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk);
        chk("dropped_pready", 64'(s_pready), 64'd0);
        run_xfer("after_drop", 32'h1A10_1004, 32'h0, 1'b0, 3, 32'hA5A5_0001, 1'b0, 10'h002);

        // Reset during ACCESS to I2C
        wait_cfg[5] = 20;
        @(posedge clk); #1;
        s_paddr = 32'h1A10_5000; s_psel = 1'b1; s_penable = 1'b0;
        @(posedge clk); #1; s_penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_access", 64'(m_penable), 64'h020);
        #2 rst = 1'b1;
        #1;
        chk("midrst_psel", 64'(m_psel), 64'd0);
        chk("midrst_penable", 64'(m_penable), 64'd0);
        chk("midrst_pready", 64'(s_pready), 64'd0);
        @(posedge clk); #1; s_psel = 1'b0; s_penable = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        wait_cfg[5] = 0;
        run_xfer("after_reset", 32'h1A10_5000, 32'h0, 1'b0, 3, 32'hA5A5_0005, 1'b0, 10'h020);

`ifdef APB_NODE_TIMEOUT_EN
        // SPI never ready: 8 ACCESS cycles (2..9), forced response at cycle 10
        wait_cfg[2] = 1000;
        run_xfer("timeout", 32'h1A10_2000, 32'h0, 1'b0, 10, 32'h0, 1'b1, 10'h004);
        wait_cfg[2] = 0;
`endif

        // Randomized transfers against the behavioural map model
        for (int n = 0; n < 40; n++) begin : g_rand
            int          p;
            int          rp;
            logic [31:0] a;
            logic [31:0] wd;
            logic        wr;
            p = $urandom_range(0, NB - 1);
            wait_cfg[p]  = $urandom_range(0, 3);
            err_cfg[p]   = 1'($urandom);
            rdata_cfg[p] = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else                          a = st[p] + ($urandom & 32'h0000_0FFF);
            wd = $urandom;
            wr = 1'($urandom);
            rp = ref_port(a);
            if (rp >= 0)
                run_xfer($sformatf("rnd%0d", n), a, wd, wr, 3 + wait_cfg[rp],
                         rdata_cfg[rp], err_cfg[rp], NB'(1) << rp);
            else
                run_xfer($sformatf("rnd%0d", n), a, wd, wr, 2, 32'h0, 1'b1, '0);
        end

        @(negedge clk);
        chk("timeout_pulses", 64'(to_cnt), 64'(EXP_TO_PULSES));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_node_reg.md
Name: apb_node_reg

Overview:
- Registered APB 1-to-NB_MASTER node: one upstream APB slave port fans out to NB_MASTER downstream APB master ports.
- Address map is supplied at runtime through per-port start/end address inputs; it is not hard-wired.
- Each transfer is re-sequenced downstream with a clean SETUP/ACCESS pair.
- An unmapped address is terminated locally with PSLVERR.
- Sits between the AXI-to-APB bridge and the SoC peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, cipher, debug).

Parameters:
- NB_MASTER, 10, number of downstream ports.
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_paddr  in  APB_ADDR_WIDTH  upstream address
- s_pwdata  in  APB_DATA_WIDTH  upstream write data
- s_pwrite  in  1  upstream write strobe
- s_psel  in  1  upstream select
- s_penable  in  1  upstream enable
- s_prdata  out  APB_DATA_WIDTH  upstream read data
- s_pready  out  1  upstream ready
- s_pslverr  out  1  upstream error
- m_paddr  out  APB_ADDR_WIDTH  shared downstream address
- m_pwdata  out  APB_DATA_WIDTH  shared downstream write data
- m_pwrite  out  1  shared downstream write
- m_psel  out  NB_MASTER  one-hot downstream select
- m_penable  out  NB_MASTER  per-port enable
- m_prdata  in  NB_MASTER*APB_DATA_WIDTH  packed read data; port i occupies [i*W +: W]
- m_pready  in  NB_MASTER  per-port ready
- m_pslverr  in  NB_MASTER  per-port error
- start_addr  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region start, per port
- end_addr  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region end, per port
- timeout  out  1  one-cycle pulse on a forced timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched address, data, write and index registers all 0.
- Decode:
  - Port i hits when start_addr[i] <= addr <= end_addr[i], unsigned comparison.
  - If several ports hit, the lowest index wins.
  - A region with start > end never hits.
  - start_addr/end_addr are sampled only in the IDLE decode cycle.
- FSM states: IDLE, SETUP, ACCESS, ERR, RESP.
- IDLE:
  - On s_psel=1 && s_penable=0, latch paddr, pwdata, pwrite and the decoded index.
  - Hit -> SETUP; miss -> ERR.
  - s_psel=1 with s_penable=1 in IDLE (protocol violation) is ignored.
- SETUP:
  - m_psel[idx]=1, m_penable=0; m_paddr/m_pwdata/m_pwrite driven from the latched registers.
  - Always -> ACCESS next cycle.
- ACCESS:
  - m_psel[idx]=1, m_penable[idx]=1; hold until m_pready[idx]=1.
  - On ready, register m_prdata[idx] and m_pslverr[idx] -> RESP.
  - Only m_pready[idx] is observed; ready on any other port is ignored.
- ERR: s_prdata=0, s_pslverr=1 -> RESP (no downstream activity).
- RESP:
  - If s_psel && s_penable: s_pready=1 for exactly one cycle, with s_prdata/s_pslverr valid in that cycle, then -> IDLE.
  - If the upstream has dropped s_psel: -> IDLE without asserting s_pready.
- Outside RESP: s_pready=0 and s_pslverr=0; s_prdata holds its last value.
- Latency: with a zero-wait-state slave, upstream setup at cycle 0 gives s_pready at cycle 3; each downstream wait state adds 1 cycle. A miss responds at cycle 2.
- m_psel is never more than one-hot; it is all-zero in IDLE, ERR and RESP.
- Back-to-back transfers: a new upstream setup is accepted in IDLE only, i.e. no earlier than the cycle after RESP.
- Reset mid-transfer: all selects drop immediately (asynchronous); the downstream transfer is abandoned and no response is issued.

Optional Feature:
- Macro: APB_NODE_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES-1 without m_pready[idx]: drop m_psel/m_penable, force s_prdata=0 and s_pslverr=1, pulse timeout for 1 cycle, go to RESP.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter; ACCESS waits indefinitely; timeout is tied to 0.

Decomposition:
- Package apb_node_pkg:
  - state enum node_state_e;
  - default map constants (UART 0x1A10_0000..0FFF through DEBUG 0x1A11_0000..7FFF);
  - function for the index width, max(1, $clog2(NB_MASTER)).
- One sub-module, apb_addr_decoder: combinational priority decode producing hit and idx. The node itself holds the FSM, the registers and the timeout logic.

Test Plan:
All scenarios use the default map loaded in order UART, GPIO, SPI, TIMER, EVENT, I2C, FLL, SOC_CTRL, CIPHER, DEBUG.
1. Read of 0x1A10_1004, GPIO returns 0xA5A5_0001 with zero wait -> m_psel=0x002 in cycles 1-2; s_pready at cycle 3 with s_prdata=0xA5A5_0001 and s_pslverr=0.
2. Write 0x1234_5678 to 0x1A10_3008, TIMER inserts 4 wait states -> m_pwdata stable throughout; s_pready at cycle 7; m_psel/m_penable cleared at cycle 7.
3. Read of 0x2000_0000 (unmapped) -> no m_psel activity; s_pready=1, s_pslverr=1 and s_prdata=0 at cycle 2.
4. Overlap: port 3 range moved to 0x1A10_1000..1FFF, then access 0x1A10_1800 -> port 1 selected (lowest index wins).
5. With APB_NODE_TIMEOUT_EN and TIMEOUT_CYCLES=8, SPI never asserts ready -> timeout pulses once; s_pslverr=1; SPI select drops after 8 ACCESS cycles.
6. rst asserted during ACCESS to I2C -> m_psel=0 and s_pready=0 immediately; after release the next transfer completes normally.
